// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and LSB results onto one registered broadcast per cycle,
// round-robin on contention, with a small holding FIFO per source so losers are kept in order.
module cdb_arbiter #(
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob,
  input  logic [DATA_W-1:0] alu_value,
  input  logic              alu_jump,
  input  logic [DATA_W-1:0] alu_target,
  output logic              alu_full,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_full,
  output logic              cdb_valid,
  output logic              cdb_src,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_jump,
  output logic [DATA_W-1:0] cdb_target
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  // ALU FIFO storage
  logic [DEPTH-1:0][ROB_W-1:0]  a_rob_q, a_rob_d;
  logic [DEPTH-1:0][DATA_W-1:0] a_val_q, a_val_d;
  logic [DEPTH-1:0]             a_jmp_q, a_jmp_d;
  logic [DEPTH-1:0][DATA_W-1:0] a_tgt_q, a_tgt_d;
  logic [PW-1:0]                a_rd_q, a_rd_d, a_wr_q, a_wr_d;
  logic [CW-1:0]                a_cnt_q, a_cnt_d;

  // LSB FIFO storage
  logic [DEPTH-1:0][ROB_W-1:0]  l_rob_q, l_rob_d;
  logic [DEPTH-1:0][DATA_W-1:0] l_val_q, l_val_d;
  logic [PW-1:0]                l_rd_q, l_rd_d, l_wr_q, l_wr_d;
  logic [CW-1:0]                l_cnt_q, l_cnt_d;

  logic              last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_src_q, cdb_src_d;
  logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic              cdb_jump_q, cdb_jump_d;
  logic [DATA_W-1:0] cdb_target_q, cdb_target_d;

  logic              a_head, l_head, a_cand, l_cand, grant_a, grant_l;
  logic              a_push, a_pop, l_push, l_pop;
  logic [ROB_W-1:0]  a_c_rob, l_c_rob;
  logic [DATA_W-1:0] a_c_val, a_c_tgt, l_c_val;
  logic              a_c_jmp;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign alu_full = (a_cnt_q == CW'(DEPTH));
  assign lsb_full = (l_cnt_q == CW'(DEPTH));

  // A queued head always beats the live input so per-source order is kept.
  always_comb begin
    a_head  = (a_cnt_q != '0);
    l_head  = (l_cnt_q != '0);
    a_cand  = a_head || (alu_valid && !alu_full);
    l_cand  = l_head || (lsb_valid && !lsb_full);
    grant_a = a_cand && (!l_cand || last_grant_q);
    grant_l = l_cand && !grant_a;
    a_pop   = grant_a && a_head;
    l_pop   = grant_l && l_head;
    a_push  = alu_valid && !alu_full && !(grant_a && !a_head);
    l_push  = lsb_valid && !lsb_full && !(grant_l && !l_head);
    a_c_rob = a_head ? a_rob_q[a_rd_q] : alu_rob;
    a_c_val = a_head ? a_val_q[a_rd_q] : alu_value;
    a_c_jmp = a_head ? a_jmp_q[a_rd_q] : alu_jump;
    a_c_tgt = a_head ? a_tgt_q[a_rd_q] : alu_target;
    l_c_rob = l_head ? l_rob_q[l_rd_q] : lsb_rob;
    l_c_val = l_head ? l_val_q[l_rd_q] : lsb_value;
  end

  always_comb begin
    a_rob_d      = a_rob_q;
    a_val_d      = a_val_q;
    a_jmp_d      = a_jmp_q;
    a_tgt_d      = a_tgt_q;
    a_rd_d       = a_rd_q;
    a_wr_d       = a_wr_q;
    a_cnt_d      = a_cnt_q;
    l_rob_d      = l_rob_q;
    l_val_d      = l_val_q;
    l_rd_d       = l_rd_q;
    l_wr_d       = l_wr_q;
    l_cnt_d      = l_cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_src_d    = cdb_src_q;
    cdb_rob_d    = cdb_rob_q;
    cdb_value_d  = cdb_value_q;
    cdb_jump_d   = cdb_jump_q;
    cdb_target_d = cdb_target_q;

    if (clear) begin
      a_rd_d       = '0;
      a_wr_d       = '0;
      a_cnt_d      = '0;
      l_rd_d       = '0;
      l_wr_d       = '0;
      l_cnt_d      = '0;
      cdb_valid_d  = 1'b0;
      last_grant_d = 1'b1;
    end else if (rdy_in) begin
      if (a_push) begin
        a_rob_d[a_wr_q] = alu_rob;
        a_val_d[a_wr_q] = alu_value;
        a_jmp_d[a_wr_q] = alu_jump;
        a_tgt_d[a_wr_q] = alu_target;
        a_wr_d          = next_ptr(a_wr_q);
      end
      if (a_pop) a_rd_d = next_ptr(a_rd_q);
      a_cnt_d = a_cnt_q + CW'(a_push) - CW'(a_pop);

      if (l_push) begin
        l_rob_d[l_wr_q] = lsb_rob;
        l_val_d[l_wr_q] = lsb_value;
        l_wr_d          = next_ptr(l_wr_q);
      end
      if (l_pop) l_rd_d = next_ptr(l_rd_q);
      l_cnt_d = l_cnt_q + CW'(l_push) - CW'(l_pop);

      cdb_valid_d = grant_a || grant_l;
      if (grant_a) begin
        cdb_src_d    = 1'b0;
        cdb_rob_d    = a_c_rob;
        cdb_value_d  = a_c_val;
        cdb_jump_d   = a_c_jmp;
        cdb_target_d = a_c_tgt;
        last_grant_d = 1'b0;
      end else if (grant_l) begin
        cdb_src_d    = 1'b1;
        cdb_rob_d    = l_c_rob;
        cdb_value_d  = l_c_val;
        cdb_jump_d   = 1'b0;
        cdb_target_d = '0;
        last_grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_rob_q      <= '0;
      a_val_q      <= '0;
      a_jmp_q      <= '0;
      a_tgt_q      <= '0;
      a_rd_q       <= '0;
      a_wr_q       <= '0;
      a_cnt_q      <= '0;
      l_rob_q      <= '0;
      l_val_q      <= '0;
      l_rd_q       <= '0;
      l_wr_q       <= '0;
      l_cnt_q      <= '0;
      last_grant_q <= 1'b1;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_value_q  <= '0;
      cdb_jump_q   <= 1'b0;
      cdb_target_q <= '0;
    end else begin
      a_rob_q      <= a_rob_d;
      a_val_q      <= a_val_d;
      a_jmp_q      <= a_jmp_d;
      a_tgt_q      <= a_tgt_d;
      a_rd_q       <= a_rd_d;
      a_wr_q       <= a_wr_d;
      a_cnt_q      <= a_cnt_d;
      l_rob_q      <= l_rob_d;
      l_val_q      <= l_val_d;
      l_rd_q       <= l_rd_d;
      l_wr_q       <= l_wr_d;
      l_cnt_q      <= l_cnt_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_src_q    <= cdb_src_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_value_q  <= cdb_value_d;
      cdb_jump_q   <= cdb_jump_d;
      cdb_target_q <= cdb_target_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_src    = cdb_src_q;
  assign cdb_rob    = cdb_rob_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_jump   = cdb_jump_q;
  assign cdb_target = cdb_target_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cdb_arbiter;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b1;
  logic              clr = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ROB_W-1:0]  alu_rob = '0;
  logic [DATA_W-1:0] alu_value = '0;
  logic              alu_jump = 1'b0;
  logic [DATA_W-1:0] alu_target = '0;
  logic              alu_full;
  logic              lsb_valid = 1'b0;
  logic [ROB_W-1:0]  lsb_rob = '0;
  logic [DATA_W-1:0] lsb_value = '0;
  logic              lsb_full;
  logic              cdb_valid, cdb_src, cdb_jump;
  logic [ROB_W-1:0]  cdb_rob;
  logic [DATA_W-1:0] cdb_value, cdb_target;

  int vectors = 0;
  int errors  = 0;

  cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
    .alu_valid(alu_valid), .alu_rob(alu_rob), .alu_value(alu_value), .alu_jump(alu_jump),
    .alu_target(alu_target), .alu_full(alu_full),
    .lsb_valid(lsb_valid), .lsb_rob(lsb_rob), .lsb_value(lsb_value), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .cdb_jump(cdb_jump), .cdb_target(cdb_target)
  );

  always #5 clk = ~clk;

  // Reference model: one queue of pending results per source, plus the registered broadcast.
  typedef struct {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] val;
    logic              jmp;
    logic [DATA_W-1:0] tgt;
  } ent_t;

  ent_t              aq[$];
  ent_t              lq[$];
  logic              m_lg;
  logic              m_valid, m_src, m_jump;
  logic [ROB_W-1:0]  m_rob;
  logic [DATA_W-1:0] m_value, m_target;

  logic [72:0] dut_vec;
  assign dut_vec = {cdb_valid, cdb_src, cdb_rob, cdb_value, cdb_jump, cdb_target,
                    alu_full, lsb_full};

  function automatic logic [72:0] exp_vec();
    return {m_valid, m_src, m_rob, m_value, m_jump, m_target,
            aq.size() == DEPTH, lq.size() == DEPTH};
  endfunction

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m_lg = 1'b1;
    m_valid = 1'b0; m_src = 1'b0; m_rob = '0; m_value = '0; m_jump = 1'b0; m_target = '0;
  endtask

  task automatic model_edge();
    ent_t a_live, l_live, w;
    bit a_acc, l_acc, a_c, l_c, any, win_l, a_byp, l_byp;
    a_live = '{alu_rob, alu_value, alu_jump, alu_target};
    l_live = '{lsb_rob, lsb_value, 1'b0, '0};
    if (clr) begin
      aq.delete();
      lq.delete();
      m_valid = 1'b0;
      m_lg = 1'b1;
    end else if (rdy) begin
      a_acc = alu_valid && (aq.size() < DEPTH);
      l_acc = lsb_valid && (lq.size() < DEPTH);
      a_c   = (aq.size() > 0) || a_acc;
      l_c   = (lq.size() > 0) || l_acc;
      any   = a_c || l_c;
      // On contention the source that did not win last time gets the bus.
      win_l = l_c && (!a_c || !m_lg);
      a_byp = any && !win_l && aq.size() == 0;
      l_byp = any && win_l && lq.size() == 0;
      if (win_l) w = (lq.size() > 0) ? lq[0] : l_live;
      else       w = (aq.size() > 0) ? aq[0] : a_live;
      if (any && !win_l && aq.size() > 0) void'(aq.pop_front());
      if (any && win_l && lq.size() > 0) void'(lq.pop_front());
      if (a_acc && !a_byp) aq.push_back(a_live);
      if (l_acc && !l_byp) lq.push_back(l_live);
      m_valid = any;
      if (any) begin
        m_src    = win_l;
        m_rob    = w.rob;
        m_value  = w.val;
        m_jump   = win_l ? 1'b0 : w.jmp;
        m_target = win_l ? '0 : w.tgt;
        m_lg     = win_l;
      end
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, land on the next negedge.
  task automatic step(input bit av, input int ar, input bit lv, input int lr,
                      input bit r = 1'b1, input bit c = 1'b0);
    alu_valid  = av;
    alu_rob    = ROB_W'(ar);
    alu_value  = $urandom;
    alu_jump   = 1'($urandom_range(0, 1));
    alu_target = $urandom;
    lsb_valid  = lv;
    lsb_rob    = ROB_W'(lr);
    lsb_value  = $urandom;
    rdy        = r;
    clr        = c;
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    alu_valid = 1'b0; lsb_valid = 1'b0; rdy = 1'b1; clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    vectors++;
    if (dut_vec !== 73'd0) begin
      errors++;
      $display("FAIL reset_state: got %h, want 0", dut_vec);
    end
  endtask

  task automatic test_single_alu();
    logic [37:0] want;
    want = {1'b1, 1'b0, 4'd3, 32'h12};
    alu_value = 32'h12;
    step(1, 3, 0, 0);
    alu_valid = 1'b0;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== want[37:32] || m_value !== cdb_value
        || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL single_alu: got %h, want %h", dut_vec, exp_vec());
    end
    step(0, 0, 0, 0);
    vectors++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_alu_pulse: cdb_valid %b, want 0", cdb_valid);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    step(1, 5, 1, 6);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_0101 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL contention_first: got %h, want %h", dut_vec, exp_vec());
    end
    step(0, 0, 0, 0);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b11_0110 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL contention_second: got %h, want %h", dut_vec, exp_vec());
    end
    step(0, 0, 0, 0);
    vectors++;
    if (cdb_valid !== 1'b0 || lsb_full !== 1'b0) begin
      errors++;
      $display("FAIL contention_drain: valid %b full %b, want 0 0", cdb_valid, lsb_full);
    end
  endtask

  task automatic test_sustained();
    int ai, li, na, nl, nb, alt_bad, order_bad, model_bad;
    bit av, lv, saw_af, saw_lf;
    apply_reset();
    ai = 1; li = 9; na = 0; nl = 0; nb = 0;
    alt_bad = 0; order_bad = 0; model_bad = 0; saw_af = 0; saw_lf = 0;
    for (int cyc = 0; cyc < 40 && (na + nl) < 12; cyc++) begin
      av = (ai <= 6) && (aq.size() < DEPTH);
      lv = (li <= 14) && (lq.size() < DEPTH);
      step(av, ai, lv, li);
      if (av) ai++;
      if (lv) li++;
      if (dut_vec !== exp_vec()) model_bad++;
      saw_af |= (alu_full === 1'b1);
      saw_lf |= (lsb_full === 1'b1);
      if (cdb_valid === 1'b1) begin
        if (cdb_src !== 1'(nb % 2)) alt_bad++;
        if (cdb_src === 1'b0) begin
          if (cdb_rob !== ROB_W'(1 + na)) order_bad++;
          na++;
        end else begin
          if (cdb_rob !== ROB_W'(9 + nl)) order_bad++;
          nl++;
        end
        nb++;
      end
    end
    vectors++;
    if (model_bad != 0) begin
      errors++;
      $display("FAIL sustained_model: %0d cycles differ from model, want 0", model_bad);
    end
    vectors++;
    if (alt_bad != 0 || order_bad != 0 || na != 6 || nl != 6) begin
      errors++;
      $display("FAIL sustained_order: alt %0d order %0d alu %0d lsb %0d, want 0 0 6 6",
               alt_bad, order_bad, na, nl);
    end
    vectors++;
    if (!saw_af || !saw_lf) begin
      errors++;
      $display("FAIL sustained_full: alu_full seen %b lsb_full seen %b, want 1 1", saw_af, saw_lf);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    step(1, 1, 1, 11);
    step(1, 4, 1, 12);
    step(0, 0, 1, 13);
    vectors++;
    if (lsb_full !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL flush_setup: lsb_full %b, want 1 (vec %h vs %h)", lsb_full, dut_vec, exp_vec());
    end
    step(1, 9, 1, 9, 1, 1);
    vectors++;
    if (cdb_valid !== 1'b0 || lsb_full !== 1'b0 || alu_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: valid %b lsb_full %b alu_full %b, want 0 0 0",
               cdb_valid, lsb_full, alu_full);
    end
    step(1, 2, 0, 0);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_0010 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL flush_fresh: got %h, want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step(1, 1, 0, 0);
    step(1, 7, 1, 4);
    step(1, 8, 0, 0);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_0111 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL stall_setup: got %h, want %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 15, 1, 14, 0);
      vectors++;
      if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_0111 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h, want %h", i, dut_vec, exp_vec());
      end
    end
    step(0, 0, 0, 0);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_1000 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL stall_resume: got %h, want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1, 1, 1, 2);
    step(1, 3, 1, 4);
    step(1, 5, 1, 6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== 73'd0) begin
      errors++;
      $display("FAIL async_reset: got %h, want 0", dut_vec);
    end
    alu_valid = 1'b0; lsb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 10, 1, 11);
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob} !== 6'b10_1010 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset_grant: got %h, want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad;
    bit av, lv, r, c;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      av = ($urandom_range(0, 3) != 0) && (aq.size() < DEPTH);
      lv = ($urandom_range(0, 3) != 0) && (lq.size() < DEPTH);
      r  = ($urandom_range(0, 7) != 0);
      c  = ($urandom_range(0, 31) == 0);
      step(av, $urandom_range(0, 15), lv, $urandom_range(0, 15), r, c);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle%0d: got %h, want %h", i, dut_vec, exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_alu();
    test_contention();
    test_sustained();
    test_flush();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: ALU (fed by the RS) and LSB.
- Grants one broadcast per cycle, round-robin on contention.
- Each source has a small FIFO so losing results are never lost.
- The registered CDB output feeds the ROB, RS and LSB wake-up logic and the register-status update path that issue writes into.

Parameters:
ROB_W, 4, ROB tag width (matches ROB_Number width)
DATA_W, 32, result value width
DEPTH, 2, per-source holding FIFO depth; DEPTH >= 2, need not be a power of two

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; low freezes all state
clear  input  1  synchronous flush (branch mispredict)
alu_valid  input  1  ALU result present this cycle
alu_rob  input  ROB_W  ALU result ROB tag
alu_value  input  DATA_W  ALU result value
alu_jump  input  1  branch/jalr taken flag
alu_target  input  DATA_W  branch/jalr target pc
alu_full  output  1  ALU FIFO holds DEPTH entries
lsb_valid  input  1  LSB load/store completion present
lsb_rob  input  ROB_W  LSB ROB tag
lsb_value  input  DATA_W  loaded value (0 for stores)
lsb_full  output  1  LSB FIFO holds DEPTH entries
cdb_valid  output  1  broadcast valid
cdb_src  output  1  0 = ALU, 1 = LSB
cdb_rob  output  ROB_W  broadcast tag
cdb_value  output  DATA_W  broadcast value
cdb_jump  output  1  broadcast jump flag (0 when src = LSB)
cdb_target  output  DATA_W  broadcast target (0 when src = LSB)

Behaviour:
- Reset (async, any time, including mid-operation):
  - Both FIFOs emptied (pointers and counts = 0).
  - All cdb_* outputs = 0.
  - last_grant = 1 (LSB), so ALU wins the first contention.
  - alu_full = lsb_full = 0.
- Full flags: alu_full and lsb_full are combinational, equal to (count == DEPTH).
- Per-source candidate:
  - FIFO head if the FIFO is non-empty.
  - Otherwise the live input if *_valid and not full (bypass).
  - Otherwise none.
- Arbitration (combinational; result registered at the clk_in edge when rdy_in = 1 and clear = 0):
  - Exactly one candidate: that candidate wins.
  - Both candidates: the winner is the source != last_grant; last_grant <= winner.
  - No candidate: cdb_valid <= 0; other cdb_* hold their previous values; last_grant unchanged.
- Latency: with an empty FIFO and no contention, input in cycle N appears on the CDB for exactly cycle N+1. cdb_valid is a one-cycle pulse per result.
- FIFO update per source, per edge:
  - Pop if the winner came from that FIFO head.
  - Push the live input if *_valid, not full, and it was not consumed by bypass.
  - Simultaneous push and pop is allowed; count unchanged.
  - Pointers wrap explicitly from DEPTH-1 to 0.
  - Order within a source is preserved: the head always precedes the live input.
- Valid while full: the input is ignored (no push, no bypass). Requesters must stall on *_full; the bench checks that this case is not hit in normal operation.
- rdy_in = 0: all registers hold, including cdb_valid and its payload; inputs are ignored.
- clear = 1 (acts regardless of rdy_in), at the next edge:
  - FIFOs emptied, cdb_valid <= 0, last_grant <= 1.
  - That cycle's inputs are dropped.
  - Payload outputs may hold.
- Priority: rst_in > clear > !rdy_in > normal operation.
- Widths: counts are $clog2(DEPTH+1) bits; no arithmetic on payloads.

Test Plan:
1. Single ALU: after reset, alu_valid = 1, rob = 3, value = 0x12 for one cycle -> next cycle cdb_valid = 1, src = 0, rob = 3, value = 0x12; following cycle cdb_valid = 0.
2. Contention: ALU (rob 5, value 0xA) and LSB (rob 6, value 0xB) valid in the same cycle after reset -> cycle+1 broadcasts rob 5 (src 0), cycle+2 broadcasts rob 6 (src 1); lsb FIFO count returns to 0.
3. Sustained load (DEPTH = 2): both sources valid for 6 cycles with tags ALU 1..6 and LSB 9..14, honouring *_full -> grants alternate ALU/LSB; per-source tag order is preserved; *_full asserts and throttles; no tag is lost or duplicated.
4. Flush: two LSB entries queued, then clear = 1 -> next cycle cdb_valid = 0, lsb_full = 0; a fresh ALU rob 2 then broadcasts one cycle later.
5. Stall: rdy_in = 0 for 3 cycles while cdb_valid = 1 with rob 7 and the ALU FIFO holds rob 8 -> outputs are frozen at rob 7; after rdy_in = 1, rob 8 follows.
6. Async reset mid-stream: assert rst_in between edges with both FIFOs non-empty -> outputs are 0 immediately; after release, the first contention grants ALU.
